concatenacion: RTL and testbench

- Jump-target former for the MIPS-style datapath.
- Splices the upper nibble of the program counter onto a 28-bit pre-shifted jump field (instr_index << 2) to form the 32-bit absolute jump address.
- Sits between the jump shift-left unit and the PC-source mux in the fetch stage.
- Single registered stage with valid/stall handshake.

---
 rtl/concatenacion.sv | 96 +++++++++
 tb/tb_concatenacion.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/concatenacion.sv
// Jump-target former for the fetch stage.
// Splices the upper nibble of the program counter (or of PC+4) onto the
// pre-shifted 28-bit jump field. The result passes through one registered
// stage with a valid/stall handshake.
// Optional feature: define CONCAT_ALIGN_CHECK_EN to add the registered
// misalign flag, which reports a jump field whose low two bits are nonzero.
module concatenacion #(
  parameter int unsigned USE_PC_PLUS4 = 0,
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] output_jump,
  input  logic [31:0] PC,
  input  logic        valid_in,
  input  logic        stall,
  output logic [31:0] output_concat,
`ifdef CONCAT_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        valid_out
);

  logic [31:0] pc_plus4;
  logic [3:0]  nibble;
  logic [31:0] next_target;
  logic        accept;

  logic [31:0] concat_q, concat_d;
  logic        valid_q, valid_d;

  // The low 28 bits of both PC views never reach the output.
  logic unused_pc;
  assign unused_pc = ^{PC[27:0], pc_plus4[27:0]};

  // Form the candidate target; the +4 wraps modulo 2^32.
  always_comb begin
    pc_plus4    = PC + 32'd4;
    nibble      = (USE_PC_PLUS4 != 0) ? pc_plus4[31:28] : PC[31:28];
    next_target = {nibble, output_jump};
    accept      = valid_in & ~stall;
  end

  // Next state: hold everything under stall, else capture or go idle.
  always_comb begin
    concat_d = concat_q;
    valid_d  = valid_q;
    if (!stall) begin
      valid_d = valid_in;
      if (valid_in) begin
        concat_d = next_target;
      end
    end
  end

  // Result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      concat_q <= RESET_ADDR;
      valid_q  <= 1'b0;
    end else begin
      concat_q <= concat_d;
      valid_q  <= valid_d;
    end
  end

  assign output_concat = concat_q;
  assign valid_out     = valid_q;

`ifdef CONCAT_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Flag a misaligned target on accept; hold under stall; clear when idle.
  always_comb begin
    misalign_d = misalign_q;
    if (!stall) begin
      misalign_d = accept & (output_jump[1:0] != 2'b00);
    end
  end

  // Misalign register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_concatenacion.sv
// Self-checking bench for concatenacion. Two instances share the same
// stimulus: one takes the nibble from PC and one from PC+4. Expected values
// come from an arithmetic reference model of the jump-target rules.
module tb_concatenacion;

  localparam logic [31:0] ResetAddr = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] output_jump;
  logic [31:0] PC;
  logic        valid_in;
  logic        stall;
  logic [31:0] concat0, concat1;
  logic        valid0, valid1;
`ifdef CONCAT_ALIGN_CHECK_EN
  logic        mis0, mis1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_val0, m_val1;
  logic        m_valid;
  logic        m_mis;

  always #5 clk = ~clk;

  concatenacion #(.USE_PC_PLUS4(0), .RESET_ADDR(ResetAddr)) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .output_jump  (output_jump),
    .PC           (PC),
    .valid_in     (valid_in),
    .stall        (stall),
    .output_concat(concat0),
`ifdef CONCAT_ALIGN_CHECK_EN
    .misalign     (mis0),
`endif
    .valid_out    (valid0)
  );

  concatenacion #(.USE_PC_PLUS4(1), .RESET_ADDR(ResetAddr)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .output_jump  (output_jump),
    .PC           (PC),
    .valid_in     (valid_in),
    .stall        (stall),
    .output_concat(concat1),
`ifdef CONCAT_ALIGN_CHECK_EN
    .misalign     (mis1),
`endif
    .valid_out    (valid1)
  );

  // Target = top 4 bits of the chosen PC view, times 2^28, plus the jump field.
  function automatic logic [31:0] target(input logic [31:0] pc, input logic [27:0] j,
                                         input bit plus4);
    longint unsigned base;
    longint unsigned t;
    base = plus4 ? ((longint'(pc) + 64'd4) % 64'h1_0000_0000) : longint'(pc);
    t    = (base / 64'h1000_0000) * 64'h1000_0000 + longint'(j);
    return t[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model with the inputs seen at that edge,
  // then sample just after the edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_val0  = ResetAddr;
      m_val1  = ResetAddr;
      m_valid = 1'b0;
      m_mis   = 1'b0;
    end else if (!stall) begin
      m_valid = valid_in;
      m_mis   = valid_in && (output_jump % 4 != 0);
      if (valid_in) begin
        m_val0 = target(PC, output_jump, 1'b0);
        m_val1 = target(PC, output_jump, 1'b1);
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "/concat0"}, concat0, m_val0);
    check({tag, "/concat1"}, concat1, m_val1);
    check({tag, "/valid0"}, {31'd0, valid0}, {31'd0, m_valid});
    check({tag, "/valid1"}, {31'd0, valid1}, {31'd0, m_valid});
`ifdef CONCAT_ALIGN_CHECK_EN
    check({tag, "/mis0"}, {31'd0, mis0}, {31'd0, m_mis});
    check({tag, "/mis1"}, {31'd0, mis1}, {31'd0, m_mis});
`endif
  endtask

  initial begin
    m_val0 = 'x; m_val1 = 'x; m_valid = 1'b0; m_mis = 1'b0;
    rst_n = 1'b0; valid_in = 1'b1; stall = 1'b0;
    output_jump = 28'h1234567; PC = 32'h0;
    #1;

    // Reset held two clocks while valid_in is high.
    step(); step();
    check_all("reset");
    check("reset_const", concat0, 32'h0000_0000);

    // Basic capture, PC nibble.
    rst_n = 1'b1; PC = 32'hABCD_EF00; output_jump = 28'h1111111; valid_in = 1'b1;
    step();
    check_all("basic1");
    check("basic1_const", concat0, 32'hA111_1111);
    output_jump = 28'h2222222;
    step();
    check_all("basic2");
    check("basic2_const", concat0, 32'hA222_2222);

    // Stall holds value and valid; the stalled input is dropped.
    stall = 1'b1; output_jump = 28'h3333333;
    step(); step();
    check_all("stall");
    check("stall_const", concat0, 32'hA222_2222);
    check("stall_valid", {31'd0, valid0}, 32'd1);
    stall = 1'b0; valid_in = 1'b0;
    step();
    check_all("release_idle");
    check("idle_valid", {31'd0, valid0}, 32'd0);
    check("idle_hold", concat0, 32'hA222_2222);

    // PC+4 wrap across 2^32.
    PC = 32'hFFFF_FFFC; output_jump = 28'hABCDEF0; valid_in = 1'b1;
    step();
    check_all("wrap");
    check("wrap_plus4", concat1, 32'h0ABC_DEF0);
    check("wrap_pc", concat0, 32'hFABC_DEF0);

    // Misaligned field passes through unmodified.
    PC = 32'h5000_0000; output_jump = 28'h0000001;
    step();
    check_all("misalign1");
    check("misalign1_const", concat0, 32'h5000_0001);
    output_jump = 28'h0000004;
    step();
    check_all("misalign0");

    // Reset in the same cycle as a valid input: input not captured.
    rst_n = 1'b0; output_jump = 28'h7777777; valid_in = 1'b1;
    step();
    check_all("reset_mid");
    check("reset_mid_const", concat0, ResetAddr);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rst_n       = ($urandom_range(0, 99) >= 3);
      stall       = ($urandom_range(0, 3) == 0);
      valid_in    = ($urandom_range(0, 9) < 7);
      output_jump = 28'($urandom);
      PC          = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
      step();
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
